// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer: turns host page read / page program / block erase
// requests into the instruction + command/address byte stream for the NAND
// flash bus controller, then waits on flash ready/busy and reports the result.
//
// Handshakes (all active-high, one clk domain):
//   op_valid/op_ready : request taken on a cycle where both are high; op_*
//                       fields are captured on that same edge.
//   instr_wr/cmd_wr   : single-cycle write strobes; a strobe is only raised
//                       while the matching FIFO full flag is low in that cycle,
//                       so the FIFO may take the word on the same edge.
//   op_done/op_err    : single-cycle pulses; op_err only ever with op_done.
module flash_op_sequencer #(
  parameter int BUSY_START_CYC = 64,
  parameter int TIMEOUT_CYC    = 2000000,
  parameter int TO_W           = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_type,
  input  logic [23:0] op_row,
  input  logic [15:0] op_col,
  input  logic [11:0] op_len,
  output logic [31:0] instr,
  output logic        instr_wr,
  input  logic        instr_full,
  output logic [7:0]  cmd_data,
  output logic        cmd_wr,
  input  logic        data_full,
  input  logic        flash_rdy,
  output logic        op_done,
  output logic        op_err,
  output logic [2:0]  state_dbg
);

  // Instruction mode codes understood by the bus controller
  localparam logic [3:0] MODE_STANDBY  = 4'd0;
  localparam logic [3:0] MODE_BUS_IDLE = 4'd1;
  localparam logic [3:0] MODE_CMD      = 4'd2;
  localparam logic [3:0] MODE_ADDR     = 4'd3;
  localparam logic [3:0] MODE_DIN      = 4'd4;
  localparam logic [3:0] MODE_DOUT     = 4'd5;
  localparam logic [3:0] MODE_DOUT_END = 4'd6;
  localparam logic [3:0] MODE_WP       = 4'd7;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_PROGRAM = 2'd1;
  localparam logic [1:0] OP_ERASE   = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  localparam logic [TO_W-1:0] BUSY_LAST = TO_W'(BUSY_START_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] CNT_MAX   = '1;
  localparam logic [TO_W-1:0] CNT_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_BUSY_FALL = 3'd2,
    S_BUSY_RISE = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  // What follows a step once it has been written
  typedef enum logic [1:0] {
    NXT_CONT = 2'd0,
    NXT_BUSY = 2'd1,
    NXT_DONE = 2'd2
  } nxt_t;

  state_t           state_q, state_d;
  logic [1:0]       type_q;
  logic [23:0]      row_q;
  logic [15:0]      col_q;
  logic [11:0]      len_q;
  logic [3:0]       idx_q, idx_d;
  logic [TO_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic             capture;

  // Current step descriptor
  logic             st_valid;
  logic             st_byte_step;
  logic [3:0]       st_mode;
  logic [7:0]       st_byte;
  logic [11:0]      st_rep;
  nxt_t             st_nxt;
  logic             can_issue;

  assign state_dbg = state_q;

  // Step table: decode (operation, step index) into instruction/byte/successor
  always_comb begin
    st_valid     = 1'b1;
    st_byte_step = 1'b0;
    st_mode      = MODE_STANDBY;
    st_byte      = 8'h00;
    st_rep       = 12'h000;
    st_nxt       = NXT_CONT;
    case (type_q)
      OP_READ, OP_PROGRAM: begin
        case (idx_q)
          4'd0: begin
            st_byte_step = 1'b1;
            st_mode      = MODE_CMD;
            st_byte      = (type_q == OP_READ) ? 8'h00 : 8'h80;
          end
          4'd1: begin st_byte_step = 1'b1; st_mode = MODE_ADDR; st_byte = col_q[7:0];   end
          4'd2: begin st_byte_step = 1'b1; st_mode = MODE_ADDR; st_byte = col_q[15:8];  end
          4'd3: begin st_byte_step = 1'b1; st_mode = MODE_ADDR; st_byte = row_q[7:0];   end
          4'd4: begin st_byte_step = 1'b1; st_mode = MODE_ADDR; st_byte = row_q[15:8];  end
          4'd5: begin st_byte_step = 1'b1; st_mode = MODE_ADDR; st_byte = row_q[23:16]; end
          4'd6: begin
            if (type_q == OP_READ) begin
              st_byte_step = 1'b1;
              st_mode      = MODE_CMD;
              st_byte      = 8'h30;
              st_nxt       = NXT_BUSY;
            end else begin
              // Payload bytes come from the host straight into the data FIFO
              st_mode = MODE_DIN;
              st_rep  = len_q;
            end
          end
          4'd7: begin
            if (type_q == OP_READ) begin
              st_mode = MODE_DOUT;
              st_rep  = len_q;
            end else begin
              st_byte_step = 1'b1;
              st_mode      = MODE_CMD;
              st_byte      = 8'h10;
              st_nxt       = NXT_BUSY;
            end
          end
          4'd8: begin
            if (type_q == OP_READ) begin
              st_mode = MODE_DOUT_END;
              st_nxt  = NXT_DONE;
            end else begin
              st_valid = 1'b0;
            end
          end
          default: st_valid = 1'b0;
        endcase
      end
      OP_ERASE: begin
        case (idx_q)
          4'd0: begin st_byte_step = 1'b1; st_mode = MODE_CMD;  st_byte = 8'h60;        end
          4'd1: begin st_byte_step = 1'b1; st_mode = MODE_ADDR; st_byte = row_q[7:0];   end
          4'd2: begin st_byte_step = 1'b1; st_mode = MODE_ADDR; st_byte = row_q[15:8];  end
          4'd3: begin st_byte_step = 1'b1; st_mode = MODE_ADDR; st_byte = row_q[23:16]; end
          4'd4: begin
            st_byte_step = 1'b1;
            st_mode      = MODE_CMD;
            st_byte      = 8'hD0;
            st_nxt       = NXT_BUSY;
          end
          default: st_valid = 1'b0;
        endcase
      end
      default: st_valid = 1'b0;
    endcase
  end

  // Byte steps need room in both FIFOs; instruction-only steps need just one
  assign can_issue = st_valid && !instr_full && (!st_byte_step || !data_full);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state, counter and output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    cnt_d    = '0;
    capture  = 1'b0;
    op_ready = 1'b0;
    instr    = 32'h0000_0000;
    instr_wr = 1'b0;
    cmd_data = 8'h00;
    cmd_wr   = 1'b0;
    op_done  = 1'b0;
    op_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          capture = 1'b1;
          idx_d   = 4'd0;
          err_d   = (op_type == OP_RSVD);
          state_d = (op_type == OP_RSVD) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Word and byte are held steady while a full FIFO stalls the step
        instr    = {16'h0000, st_rep, st_mode};
        cmd_data = st_byte_step ? st_byte : 8'h00;
        if (!st_valid) begin
          state_d = S_FINISH;
        end else if (can_issue) begin
          instr_wr = 1'b1;
          cmd_wr   = st_byte_step;
          idx_d    = idx_q + 4'd1;
          case (st_nxt)
            NXT_BUSY: state_d = S_BUSY_FALL;
            NXT_DONE: state_d = S_FINISH;
            default:  state_d = S_ISSUE;
          endcase
        end
      end
      S_BUSY_FALL: begin
        // A flash that never shows busy is treated as already finished
        cnt_d = cnt_inc;
        if (!flash_rdy || (cnt_q == BUSY_LAST)) begin
          cnt_d   = '0;
          state_d = S_BUSY_RISE;
        end
      end
      S_BUSY_RISE: begin
        cnt_d = cnt_inc;
        if (flash_rdy) begin
          cnt_d   = '0;
          state_d = (type_q == OP_READ) ? S_ISSUE : S_FINISH;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        op_done = 1'b1;
        op_err  = err_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and captured request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      type_q  <= 2'd0;
      row_q   <= 24'h0;
      col_q   <= 16'h0;
      len_q   <= 12'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        type_q <= op_type;
        row_q  <= op_row;
        col_q  <= op_col;
        len_q  <= op_len;
      end
    end
  end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer: expected FIFO writes and completions
// are queued as each operation is issued; a negedge monitor pops and compares.
module tb_flash_op_sequencer;

  localparam int BUSY_CYC = 64;
  localparam int TO_CYC   = 150;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_type;
  logic [23:0] op_row;
  logic [15:0] op_col;
  logic [11:0] op_len;
  logic [31:0] instr;
  logic        instr_wr;
  logic        instr_full;
  logic [7:0]  cmd_data;
  logic        cmd_wr;
  logic        data_full;
  logic        flash_rdy;
  logic        op_done;
  logic        op_err;
  logic [2:0]  state_dbg;

  flash_op_sequencer #(
    .BUSY_START_CYC(BUSY_CYC),
    .TIMEOUT_CYC(TO_CYC),
    .TO_W(24)
  ) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .op_row(op_row), .op_col(op_col), .op_len(op_len),
    .instr(instr), .instr_wr(instr_wr), .instr_full(instr_full),
    .cmd_data(cmd_data), .cmd_wr(cmd_wr), .data_full(data_full),
    .flash_rdy(flash_rdy), .op_done(op_done), .op_err(op_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic [40:0] exp_q[$];   // {cmd_wr, cmd_data, instr}
  logic        done_q[$];  // expected op_err with each op_done
  logic [40:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [40:0] bw(input logic [3:0] mode, input logic [7:0] b);
    return {1'b1, b, 16'h0000, 12'h000, mode};
  endfunction

  function automatic logic [40:0] iw(input logic [3:0] mode, input logic [11:0] rep);
    return {1'b0, 8'h00, 16'h0000, rep, mode};
  endfunction

  // Monitor: every strobe and every completion is matched against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_wr || cmd_wr) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got instr %0h cmd_wr %0b data %0h, required no write",
                   instr, cmd_wr, cmd_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("instr_word", {32'h0, instr}, {32'h0, mon_e[31:0]});
          chk("instr_wr", {63'h0, instr_wr}, 64'h1);
          chk("cmd_wr", {63'h0, cmd_wr}, {63'h0, mon_e[40]});
          if (mon_e[40]) chk("cmd_data", {56'h0, cmd_data}, {56'h0, mon_e[39:32]});
        end
      end
      if (op_done) begin
        done_count++;
        done_cyc = cyc;
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got op_done=1 op_err=%0b, required no completion", op_err);
        end else begin
          chk("op_err", {63'h0, op_err}, {63'h0, done_q.pop_front()});
        end
      end else if (op_err) begin
        checks++;
        errors++;
        $display("FAIL op_err_alone: got op_err=1 with op_done=0, required 0");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_op(input logic [1:0] t, input logic [23:0] row,
                          input logic [15:0] col, input logic [11:0] len);
    int k;
    k = 0;
    @(negedge clk);
    while (!op_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!op_ready) begin
      checks++;
      errors++;
      $display("FAIL op_ready_wait: got op_ready=0 after %0d cycles, required 1", k);
    end
    op_valid = 1'b1;
    op_type  = t;
    op_row   = row;
    op_col   = col;
    op_len   = len;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k;
    for (k = 0; k < 500 && wr_count < n; k++) begin
      @(posedge clk);
      #2;
    end
    if (wr_count < n) begin
      checks++;
      errors++;
      $display("FAIL write_wait: got %0d writes, required %0d", wr_count, n);
    end
  endtask

  task automatic wait_done(input int start, input int budget);
    int k;
    for (k = 0; k < budget && done_count <= start; k++) begin
      @(posedge clk);
      #2;
    end
    if (done_count <= start) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no op_done within %0d cycles, required one", budget);
    end
  endtask

  task automatic check_drained(input string name);
    chk({name, "_exp_q_left"}, exp_q.size(), 0);
    chk({name, "_done_q_left"}, done_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_op_ready"}, {63'h0, op_ready}, 64'h1);
    chk({name, "_instr"}, {32'h0, instr}, 64'h0);
    chk({name, "_instr_wr"}, {63'h0, instr_wr}, 64'h0);
    chk({name, "_cmd_data"}, {56'h0, cmd_data}, 64'h0);
    chk({name, "_cmd_wr"}, {63'h0, cmd_wr}, 64'h0);
    chk({name, "_op_done"}, {63'h0, op_done}, 64'h0);
    chk({name, "_op_err"}, {63'h0, op_err}, 64'h0);
    chk({name, "_state"}, {61'h0, state_dbg}, 64'h0);
  endtask

  task automatic push_read(input logic [23:0] row, input logic [15:0] col, input logic [11:0] len);
    exp_q.push_back(bw(4'd2, 8'h00));
    exp_q.push_back(bw(4'd3, col[7:0]));
    exp_q.push_back(bw(4'd3, col[15:8]));
    exp_q.push_back(bw(4'd3, row[7:0]));
    exp_q.push_back(bw(4'd3, row[15:8]));
    exp_q.push_back(bw(4'd3, row[23:16]));
    exp_q.push_back(bw(4'd2, 8'h30));
    exp_q.push_back(iw(4'd5, len));
    exp_q.push_back(iw(4'd6, 12'h000));
    done_q.push_back(1'b0);
  endtask

  task automatic push_erase(input logic [23:0] row, input logic err);
    exp_q.push_back(bw(4'd2, 8'h60));
    exp_q.push_back(bw(4'd3, row[7:0]));
    exp_q.push_back(bw(4'd3, row[15:8]));
    exp_q.push_back(bw(4'd3, row[23:16]));
    exp_q.push_back(bw(4'd2, 8'hD0));
    done_q.push_back(err);
  endtask

  // Read with a normal busy period; data phase must wait for flash_rdy
  task automatic run_read(input logic [23:0] row, input logic [15:0] col,
                          input logic [11:0] len, input int low_cyc, input string name);
    int base;
    int dbase;
    base  = wr_count;
    dbase = done_count;
    push_read(row, col, len);
    issue_op(2'd0, row, col, len);
    wait_writes(base + 7);
    flash_rdy = 1'b0;
    repeat (low_cyc) @(posedge clk);
    chk({name, "_writes_while_busy"}, wr_count - base, 7);
    #2;
    flash_rdy = 1'b1;
    wait_done(dbase, 100);
    chk({name, "_write_total"}, wr_count - base, 9);
    check_drained(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int dbase;
    rst        = 1'b1;
    op_valid   = 1'b0;
    op_type    = 2'd0;
    op_row     = 24'h0;
    op_col     = 16'h0;
    op_len     = 12'h0;
    instr_full = 1'b0;
    data_full  = 1'b0;
    flash_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Page read, row 012345 col 0010, 2048 bytes
    run_read(24'h012345, 16'h0010, 12'd2047, 100, "read");

    // Page program with data FIFO backpressure on the third address byte
    base  = wr_count;
    dbase = done_count;
    exp_q.push_back(bw(4'd2, 8'h80));
    exp_q.push_back(bw(4'd3, 8'hBC));
    exp_q.push_back(bw(4'd3, 8'h0A));
    exp_q.push_back(bw(4'd3, 8'h56));
    exp_q.push_back(bw(4'd3, 8'h34));
    exp_q.push_back(bw(4'd3, 8'h12));
    exp_q.push_back({1'b0, 8'h00, 32'h0000_0034});
    exp_q.push_back(bw(4'd2, 8'h10));
    done_q.push_back(1'b0);
    issue_op(2'd1, 24'h123456, 16'h0ABC, 12'd3);
    repeat (3) @(posedge clk);
    #1;
    data_full = 1'b1;
    chk("prog_writes_before_stall", wr_count - base, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("prog_stall_instr_wr", {63'h0, instr_wr}, 64'h0);
      chk("prog_stall_cmd_wr", {63'h0, cmd_wr}, 64'h0);
    end
    @(posedge clk);
    #1;
    data_full = 1'b0;
    wait_writes(base + 8);
    flash_rdy = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    flash_rdy = 1'b1;
    wait_done(dbase, 100);
    chk("prog_write_total", wr_count - base, 8);
    check_drained("prog");

    // Block erase, row ABCDEF
    base  = wr_count;
    dbase = done_count;
    push_erase(24'hABCDEF, 1'b0);
    issue_op(2'd2, 24'hABCDEF, 16'h0000, 12'h000);
    wait_writes(base + 5);
    flash_rdy = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    flash_rdy = 1'b1;
    wait_done(dbase, 100);
    chk("erase_write_total", wr_count - base, 5);
    check_drained("erase");

    // Timeout: flash stays busy. One BUSY_FALL cycle sees rdy low, then
    // TO_CYC cycles in BUSY_RISE, then FINISH: TO_CYC+2 after the last write.
    base  = wr_count;
    dbase = done_count;
    push_erase(24'h000777, 1'b1);
    issue_op(2'd2, 24'h000777, 16'h0000, 12'h000);
    wait_writes(base + 5);
    flash_rdy = 1'b0;
    wait_done(dbase, TO_CYC + 50);
    chk("timeout_latency", done_cyc - last_wr_cyc, TO_CYC + 2);
    @(negedge clk);
    chk("timeout_op_ready_after", {63'h0, op_ready}, 64'h1);
    flash_rdy = 1'b1;
    check_drained("timeout");

    // Missed busy: BUSY_CYC cycles in BUSY_FALL, one in BUSY_RISE, then FINISH
    base  = wr_count;
    dbase = done_count;
    push_erase(24'h00F00D, 1'b0);
    issue_op(2'd2, 24'h00F00D, 16'h0000, 12'h000);
    wait_done(dbase, BUSY_CYC + 50);
    chk("missed_busy_latency", done_cyc - last_wr_cyc, BUSY_CYC + 2);
    check_drained("missed_busy");

    // Reserved operation: error completion with no FIFO traffic
    base  = wr_count;
    dbase = done_count;
    done_q.push_back(1'b1);
    issue_op(2'd3, 24'h111111, 16'h2222, 12'h333);
    wait_done(dbase, 20);
    chk("reserved_writes", wr_count - base, 0);
    check_drained("reserved");

    // Reset in the middle of a read after three byte writes
    base = wr_count;
    exp_q.push_back(bw(4'd2, 8'h00));
    exp_q.push_back(bw(4'd3, 8'h44));
    exp_q.push_back(bw(4'd3, 8'h33));
    issue_op(2'd0, 24'h665544, 16'h3344, 12'd15);
    repeat (3) @(posedge clk);
    #1;
    instr_full = 1'b1;
    rst        = 1'b1;
    chk("abort_writes_before_reset", wr_count - base, 3);
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("abort");
    @(posedge clk);
    #1;
    rst        = 1'b0;
    instr_full = 1'b0;
    check_drained("abort");
    run_read(24'h665544, 16'h3344, 12'd15, 10, "read_after_abort");

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #(200000);
    errors++;
    $display("FAIL watchdog: got no end of test by t=%0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
